// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - per-channel idle-driven clock-gate enable controller
module clk_gate_ctrl #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scan_cg_en_i,
    input  logic [CNT_W-1:0] idle_thr_i,
    input  logic [NCH-1:0]   auto_en_i,
    input  logic [NCH-1:0]   sw_en_i,
    input  logic [NCH-1:0]   busy_i,
    input  logic [NCH-1:0]   wake_req_i,
    output logic [NCH-1:0]   cg_en_o,
    output logic [NCH-1:0]   ready_o,
    output logic [NCH-1:0]   gated_o
);

    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("clk_gate_ctrl: WAKE_CYCLES must be at least 1");
    end
    if (WAKE_CYCLES > (2 ** CNT_W)) begin : g_bad_wake_w
        $error("clk_gate_ctrl: WAKE_CYCLES-1 must fit in CNT_W bits");
    end
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
        $error("clk_gate_ctrl: NCH must be in 1..32");
    end

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    logic             thr_zero;
    logic [CNT_W-1:0] thr_last;

    // thr_last is only consulted while keep is low, which implies a non-zero threshold
    assign thr_zero = (idle_thr_i == '0);
    assign thr_last = idle_thr_i - CNT_W'(1);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             keep;

        assign keep = busy_i[g] | wake_req_i[g] | sw_en_i[g] | ~auto_en_i[g] | thr_zero;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                ST_ON: begin
                    if (!keep) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_IDLE: begin
                    if (keep) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else if (cnt_q >= thr_last) begin
                        state_d = ST_OFF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (keep) begin
                        state_d = ST_WAKE;
                        cnt_d   = '0;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_ON;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // scan override is the only combinational path to an output
        assign cg_en_o[g] = (state_q != ST_OFF) | scan_cg_en_i;
        assign ready_o[g] = (state_q == ST_ON) | (state_q == ST_IDLE);
        assign gated_o[g] = (state_q == ST_OFF);
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - scoreboard bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

    localparam int NCH         = 4;
    localparam int CNT_W       = 8;
    localparam int WAKE_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             scan = 1'b0;
    logic [CNT_W-1:0] thr = '0;
    logic [NCH-1:0]   auto_en = '0;
    logic [NCH-1:0]   sw_en = '0;
    logic [NCH-1:0]   busy = '0;
    logic [NCH-1:0]   wake = '0;
    logic [NCH-1:0]   cg_en, ready, gated;

    clk_gate_ctrl #(
        .NCH(NCH), .CNT_W(CNT_W), .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk_i(clk), .rst_i(rst), .scan_cg_en_i(scan), .idle_thr_i(thr),
        .auto_en_i(auto_en), .sw_en_i(sw_en), .busy_i(busy), .wake_req_i(wake),
        .cg_en_o(cg_en), .ready_o(ready), .gated_o(gated)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] cg;
        logic [NCH-1:0] rdy;
        logic [NCH-1:0] gtd;
    } exp_t;

    exp_t exp_q[$];

    // reference: consecutive keep-low run length, off flag, remaining wake cycles
    int   m_run[NCH];
    bit   m_off[NCH];
    int   m_wk[NCH];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [NCH-1:0] last_cg, last_rdy, last_gtd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input logic scan_v);
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            e.cg[c]  = !m_off[c] || scan_v;
            e.rdy[c] = !m_off[c] && (m_wk[c] == 0);
            e.gtd[c] = m_off[c];
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic s, input logic [CNT_W-1:0] t,
                        input logic [NCH-1:0] a, input logic [NCH-1:0] sw,
                        input logic [NCH-1:0] b, input logic [NCH-1:0] w);
        logic [NCH-1:0] keep;
        exp_t e;
        rst = r; scan = s; thr = t; auto_en = a; sw_en = sw; busy = b; wake = w;
        keep = b | w | sw | ~a | {NCH{t == '0}};
        for (int c = 0; c < NCH; c++) begin
            if (r) begin
                m_off[c] = 0; m_run[c] = 0; m_wk[c] = 0;
            end else if (m_wk[c] > 0) begin
                m_wk[c]--;
            end else if (m_off[c]) begin
                if (keep[c]) begin
                    m_off[c] = 0; m_wk[c] = WAKE_CYCLES;
                end
            end else if (keep[c]) begin
                m_run[c] = 0;
            end else if (m_run[c] >= int'(t)) begin
                m_off[c] = 1; m_run[c] = 0;
            end else begin
                m_run[c]++;
            end
        end
        exp_q.push_back(model_out(s));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("cg_en", 32'(cg_en), 32'(e.cg));
            chk("ready", 32'(ready), 32'(e.rdy));
            chk("gated", 32'(gated), 32'(e.gtd));
        end
        last_cg = cg_en; last_rdy = ready; last_gtd = gated;
    endtask

    initial begin
        int fall;
        bit never_fell;
        exp_t e;

        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_off[c] = 0; m_wk[c] = 0;
        end

        // reset state
        step(1, 0, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0);
        step(1, 0, 8'd3, 4'hF, 4'h0, 4'h0, 4'h0);
        chk("rst_cg", 32'(last_cg), 32'hF);
        chk("rst_ready", 32'(last_rdy), 32'hF);
        chk("rst_gated", 32'(last_gtd), 32'h0);

        // auto-gate ch0 with threshold 3
        fall = -1;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 8'd3, 4'b0001, 4'h0, 4'h0, 4'h0);
            if (fall < 0 && !last_cg[0]) fall = i;
        end
        chk("ag_fall_cycle", 32'(fall), 32'd4);
        chk("ag_gated0", 32'(last_gtd[0]), 32'd1);
        chk("ag_ready0", 32'(last_rdy[0]), 32'd0);

        // wake pulse on ch0
        step(0, 0, 8'd3, 4'b0001, 4'h0, 4'h0, 4'b0001);
        chk("wk_cg0_next", 32'(last_cg[0]), 32'd1);
        fall = (last_rdy[0]) ? 1 : -1;
        for (int i = 2; i <= 8; i++) begin
            step(0, 0, 8'd3, 4'b0001, 4'h0, 4'h0, 4'h0);
            if (fall < 0 && last_rdy[0]) fall = i;
        end
        chk("wk_ready_cycle", 32'(fall), 32'd3);

        // abort idle on ch1 with threshold 5
        never_fell = 1;
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 8'd5, 4'b0010, 4'h0, (i == 4) ? 4'b0010 : 4'h0, 4'h0);
            if (i <= 4 && !last_cg[1]) never_fell = 0;
        end
        chk("ab_never_fell", 32'(never_fell), 32'd1);
        fall = -1;
        for (int i = 2; i <= 8; i++) begin
            step(0, 0, 8'd5, 4'b0010, 4'h0, 4'h0, 4'h0);
            if (fall < 0 && !last_cg[1]) fall = i;
        end
        chk("ab_fresh_fall", 32'(fall), 32'd6);

        // threshold 0 never gates
        never_fell = 1;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 8'd0, 4'hF, 4'h0, 4'h0, 4'h0);
            if (last_gtd != '0) never_fell = 0;
        end
        chk("thr0_no_gate", 32'(never_fell), 32'd1);

        // gate everything, then apply scan override
        for (int i = 0; i < 4; i++) step(0, 0, 8'd2, 4'hF, 4'h0, 4'h0, 4'h0);
        chk("sc_all_off", 32'(gated), 32'hF);
        scan = 1'b1;
        #1;
        e = model_out(1'b1);
        chk("sc_cg_same_cycle", 32'(cg_en), 32'(e.cg));
        chk("sc_gated_held", 32'(gated), 32'hF);
        for (int i = 0; i < 3; i++) step(0, 1, 8'd2, 4'hF, 4'h0, 4'h0, 4'h0);
        step(0, 0, 8'd2, 4'hF, 4'h0, 4'h0, 4'h0);
        chk("sc_state_kept", 32'(cg_en), 32'h0);

        // reset in the middle of WAKE
        step(0, 0, 8'd3, 4'hF, 4'h0, 4'h0, 4'hF);
        chk("rw_in_wake", 32'(last_rdy), 32'h0);
        step(1, 0, 8'd3, 4'hF, 4'h0, 4'h0, 4'h0);
        chk("rw_ready", 32'(last_rdy), 32'hF);
        fall = -1;
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 8'd3, 4'b0001, 4'h0, 4'h0, 4'h0);
            if (fall < 0 && !last_cg[0]) fall = i;
        end
        chk("rw_regate", 32'(fall), 32'd4);

        // independence: ch0/ch2 idle together, ch1 busy, ch3 forced on
        step(1, 0, 8'd3, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 8'd3, 4'hF, 4'b1000, 4'b0010, 4'h0);
            if (i == 3) chk("ind_before", 32'(last_cg), 32'hF);
            if (i == 4) chk("ind_fall", 32'(last_cg), 32'b1010);
        end

        // randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
                 CNT_W'($urandom_range(0, 4)), NCH'($urandom | $urandom),
                 NCH'($urandom & $urandom & $urandom & $urandom),
                 NCH'($urandom & $urandom & $urandom),
                 NCH'($urandom & $urandom & $urandom & $urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
